// File: rtl/membus_arbiter.sv
// membus_arbiter
// ----------------------------------------------------------------------------
// Shares one RAM slave port between the instruction-fetch bus (32-bit data,
// read-only) and the load/store bus (64-bit data, read/write).
//  - One request is granted per cycle. The data side has priority, but after
//    MAX_D_STREAK back-to-back d grants with a fetch waiting, the fetch wins.
//  - Byte addresses are turned into RAM word addresses.
//  - Each accepted request leaves a tag {src, addr[2]} in a small FIFO. The
//    in-order slave responses pop it to route the data to the right requester.
//    For fetches the tag also selects the 32-bit half of the word.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   i_valid/i_ready, i_addr         fetch request
//   i_rvalid, i_rdata               fetch response (32-bit)
//   d_valid/d_ready, d_addr, d_wen,
//   d_wdata, d_wmask                load/store request
//   d_rvalid, d_rdata               load/store response (64-bit)
//   m_valid/m_ready, m_addr, m_wen,
//   m_wdata, m_wmask                slave request
//   m_rvalid, m_rdata               slave response (one per accept, in order)
//   err_unexpected                  sticky: response arrived with no tag
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Once valid is raised, the requester holds it and the payload steady
// until it sees ready. Ready may drop when the grant moves to the other side.
// The request path is purely combinational, so the slave sees the accept in
// the same cycle.
// ----------------------------------------------------------------------------
module membus_arbiter #(
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int RAM_DATA_WIDTH = 64,
  parameter int XLEN           = 32,
  parameter int OUTSTANDING    = 2,
  parameter int MAX_D_STREAK   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_valid,
  output logic                        i_ready,
  input  logic [XLEN-1:0]             i_addr,
  output logic                        i_rvalid,
  output logic [31:0]                 i_rdata,
  input  logic                        d_valid,
  output logic                        d_ready,
  input  logic [XLEN-1:0]             d_addr,
  input  logic                        d_wen,
  input  logic [RAM_DATA_WIDTH-1:0]   d_wdata,
  input  logic [RAM_DATA_WIDTH/8-1:0] d_wmask,
  output logic                        d_rvalid,
  output logic [RAM_DATA_WIDTH-1:0]   d_rdata,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [RAM_ADDR_WIDTH-1:0]   m_addr,
  output logic                        m_wen,
  output logic [RAM_DATA_WIDTH-1:0]   m_wdata,
  output logic [RAM_DATA_WIDTH/8-1:0] m_wmask,
  input  logic                        m_rvalid,
  input  logic [RAM_DATA_WIDTH-1:0]   m_rdata,
  output logic                        err_unexpected
);

  localparam int BYTE_OFF = $clog2(RAM_DATA_WIDTH / 8);
  localparam int PTR_W    = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W    = $clog2(OUTSTANDING + 1);
  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);

  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(OUTSTANDING);
  localparam logic [PTR_W-1:0]    PTR_LAST   = PTR_W'(OUTSTANDING - 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  typedef struct packed {
    logic src_d;    // 1 = load/store, 0 = fetch
    logic hi_half;  // addr[2]: which 32-bit half a fetch wants
  } tag_t;

  tag_t                r_tags [OUTSTANDING];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [STREAK_W-1:0] r_streak;
  logic                r_err;

  logic w_full;
  logic w_grant_i;
  logic w_grant_d;
  logic w_accept;
  logic w_pop;
  tag_t w_push_tag;
  tag_t w_head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // full is taken from the registered count, before any pop this cycle, so
  // a full FIFO never grants even while a response drains it.
  assign w_full = (r_count == CNT_FULL);

  always_comb begin
    w_grant_i = 1'b0;
    w_grant_d = 1'b0;
    if (!w_full) begin
      if (i_valid && d_valid) begin
        if (r_streak == STREAK_MAX) w_grant_i = 1'b1;
        else                        w_grant_d = 1'b1;
      end else begin
        w_grant_i = i_valid;
        w_grant_d = d_valid;
      end
    end
  end

  always_comb begin
    m_valid = w_grant_i | w_grant_d;
    m_addr  = '0;
    m_wen   = 1'b0;
    m_wdata = '0;
    m_wmask = '0;
    if (w_grant_d) begin
      m_addr  = d_addr[BYTE_OFF +: RAM_ADDR_WIDTH];
      m_wen   = d_wen;
      m_wdata = d_wdata;
      m_wmask = d_wmask;
    end else if (w_grant_i) begin
      m_addr  = i_addr[BYTE_OFF +: RAM_ADDR_WIDTH];
    end
  end

  assign i_ready  = m_ready & w_grant_i;
  assign d_ready  = m_ready & w_grant_d;
  assign w_accept = m_valid & m_ready;

  assign w_push_tag.src_d   = w_grant_d;
  assign w_push_tag.hi_half = w_grant_d ? d_addr[2] : i_addr[2];

  assign w_pop  = m_rvalid && (r_count != '0);
  assign w_head = r_tags[r_rd_ptr];

  always_comb begin
    i_rvalid = 1'b0;
    d_rvalid = 1'b0;
    i_rdata  = '0;
    d_rdata  = '0;
    if (w_pop) begin
      if (w_head.src_d) begin
        d_rvalid = 1'b1;
        d_rdata  = m_rdata;
      end else begin
        i_rvalid = 1'b1;
        i_rdata  = w_head.hi_half ? m_rdata[63:32] : m_rdata[31:0];
      end
    end
  end

  assign err_unexpected = r_err;

  // Tag storage carries no reset: the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_accept) r_tags[r_wr_ptr] <= w_push_tag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_streak <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)    r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      // The streak only counts d wins that made a fetch wait.
      if (!i_valid || (w_accept && w_grant_i))
        r_streak <= '0;
      else if (w_accept && w_grant_d && (r_streak != STREAK_MAX))
        r_streak <= r_streak + STREAK_W'(1);
      if (m_rvalid && (r_count == '0)) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_membus_arbiter.sv
`timescale 1ns/1ps
module tb_membus_arbiter;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int XL = 32;
  localparam int OS = 2;
  localparam int MS = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [XL-1:0] i_addr = '0;
  logic          i_rvalid;
  logic [31:0]   i_rdata;
  logic          d_valid = 1'b0;
  logic          d_ready;
  logic [XL-1:0] d_addr = '0;
  logic          d_wen = 1'b0;
  logic [DW-1:0] d_wdata = '0;
  logic [7:0]    d_wmask = '0;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [AW-1:0] m_addr;
  logic          m_wen;
  logic [DW-1:0] m_wdata;
  logic [7:0]    m_wmask;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          err_unexpected;

  membus_arbiter #(
    .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW), .XLEN(XL),
    .OUTSTANDING(OS), .MAX_D_STREAK(MS)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_wen(d_wen),
    .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
    .m_wdata(m_wdata), .m_wmask(m_wmask),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .err_unexpected(err_unexpected)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  // Scoreboard entry: {src_d, expected response data (fetch half zero-extended)}
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] rdata_tab [1024];

  // Reference model state
  int mdl_out     = 0;  // accepted but unanswered
  int mdl_streak  = 0;  // d wins while a fetch waits
  int mdl_acc_cnt = 0;
  bit mdl_err     = 1'b0;

  // Slave model: sequence numbers of accepted requests awaiting a response
  int slv_q[$];
  int slv_cnt = 0;

  bit mon_en = 1'b0;
  bit hold_rsp = 1'b0;
  int p_i = 0, p_d = 0, p_ready = 100, p_rsp = 100;

  // Values seen at the negedge, consumed at the following posedge
  bit s_rst, s_acc_i, s_acc_d, s_i_valid, s_m_rvalid, s_dut_acc, s_i_hs, s_d_hs;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    bit g_i, g_d;
    logic [DW:0]   e;
    logic [XL-1:0] wa;
    logic [DW-1:0] rd;
    g_i = 1'b0;
    g_d = 1'b0;
    if (mon_en) begin
      // Grant as described: nothing when full, d first, i after MS d wins.
      if (mdl_out < OS) begin
        if (i_valid && d_valid) begin
          if (mdl_streak == MS) g_i = 1'b1; else g_d = 1'b1;
        end else if (i_valid) g_i = 1'b1;
        else if (d_valid) g_d = 1'b1;
      end
      check("m_valid", 64'(m_valid), 64'(g_i | g_d));
      check("i_ready", 64'(i_ready), 64'(g_i & m_ready));
      check("d_ready", 64'(d_ready), 64'(g_d & m_ready));
      if (g_i) begin
        wa = i_addr / 8;
        check("m_addr_i", 64'(m_addr), 64'(wa[AW-1:0]));
        check("m_wen_i", 64'(m_wen), 64'd0);
        check("m_wmask_i", 64'(m_wmask), 64'd0);
        check("m_wdata_i", m_wdata, 64'd0);
      end
      if (g_d) begin
        wa = d_addr / 8;
        check("m_addr_d", 64'(m_addr), 64'(wa[AW-1:0]));
        check("m_wen_d", 64'(m_wen), 64'(d_wen));
        check("m_wmask_d", 64'(m_wmask), 64'(d_wmask));
        check("m_wdata_d", m_wdata, d_wdata);
      end
      if (i_rvalid || d_rvalid || (m_rvalid && mdl_out > 0)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rsp_spurious: got i_rvalid=%0b d_rvalid=%0b expected no response", i_rvalid, d_rvalid);
        end else begin
          e = exp_q.pop_front();
          check("i_rvalid", 64'(i_rvalid), 64'(!e[DW]));
          check("d_rvalid", 64'(d_rvalid), 64'(e[DW]));
          if (e[DW]) begin
            check("d_rdata", d_rdata, e[DW-1:0]);
            check("i_rdata_idle", 64'(i_rdata), 64'd0);
          end else begin
            check("i_rdata", 64'(i_rdata), 64'(e[31:0]));
            check("d_rdata_idle", d_rdata, 64'd0);
          end
        end
      end else begin
        check("i_rvalid_idle", 64'(i_rvalid), 64'd0);
        check("d_rvalid_idle", 64'(d_rvalid), 64'd0);
        check("i_rdata_zero", 64'(i_rdata), 64'd0);
        check("d_rdata_zero", d_rdata, 64'd0);
      end
      check("err_unexpected", 64'(err_unexpected), 64'(mdl_err));
      if ((g_i || g_d) && m_ready) begin
        rd = rdata_tab[mdl_acc_cnt % 1024];
        if (g_d)          exp_q.push_back({1'b1, rd});
        else if (i_addr[2]) exp_q.push_back({1'b0, 32'd0, rd[63:32]});
        else              exp_q.push_back({1'b0, 32'd0, rd[31:0]});
        mdl_acc_cnt++;
      end
    end
    s_rst      = rst;
    s_acc_i    = g_i && m_ready;
    s_acc_d    = g_d && m_ready;
    s_i_valid  = i_valid;
    s_m_rvalid = m_rvalid;
    s_dut_acc  = m_valid && m_ready;
    s_i_hs     = i_valid && i_ready;
    s_d_hs     = d_valid && d_ready;
  end

  // ---------------- driver: one clock step ----------------
  task automatic tick();
    @(posedge clk);
    if (s_rst) begin
      mdl_out    = 0;
      mdl_streak = 0;
      mdl_err    = 1'b0;
      exp_q.delete();
      slv_q.delete();
    end else begin
      if (s_m_rvalid) begin
        if (mdl_out > 0) mdl_out--;
        else             mdl_err = 1'b1;
      end
      if (s_acc_i || s_acc_d) mdl_out++;
      if (!s_i_valid || s_acc_i)           mdl_streak = 0;
      else if (s_acc_d && mdl_streak < MS) mdl_streak++;
      if (s_m_rvalid && slv_q.size() > 0) void'(slv_q.pop_front());
      if (s_dut_acc) slv_q.push_back(slv_cnt);
    end
    if (s_dut_acc) slv_cnt++;
    #1;
    // Requesters hold a request until it is taken.
    if (!i_valid || s_i_hs) begin
      i_valid = ($urandom_range(0, 99) < p_i);
      i_addr  = $urandom;
    end
    if (!d_valid || s_d_hs) begin
      d_valid = ($urandom_range(0, 99) < p_d);
      d_addr  = $urandom;
      d_wen   = $urandom_range(0, 1);
      d_wdata = {$urandom, $urandom};
      d_wmask = 8'($urandom);
    end
    m_ready  = ($urandom_range(0, 99) < p_ready);
    m_rvalid = !hold_rsp && (slv_q.size() > 0) && ($urandom_range(0, 99) < p_rsp);
    if (m_rvalid) m_rdata = rdata_tab[slv_q[0] % 1024];
    else          m_rdata = {$urandom, $urandom};
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit drained;
    foreach (rdata_tab[k]) rdata_tab[k] = {$urandom, $urandom};
    rst = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    rst = 1'b0;

    // Both sides always asking with a fast slave: d wins MS times, then i.
    p_i = 100; p_d = 100; p_ready = 100; p_rsp = 100;
    repeat (40) tick();

    // Random traffic with varying pressure; slow slave fills the FIFO.
    for (int blk = 0; blk < 16; blk++) begin
      p_i     = $urandom_range(20, 100);
      p_d     = $urandom_range(20, 100);
      p_ready = $urandom_range(40, 100);
      p_rsp   = $urandom_range(10, 90);
      repeat (100) tick();
    end

    // Drain everything, bounded.
    p_i = 0; p_d = 0; p_ready = 100; p_rsp = 100;
    drained = 1'b0;
    for (int c = 0; c < 200 && !drained; c++) begin
      tick();
      drained = !i_valid && !d_valid && (slv_q.size() == 0);
    end
    check("drain_done", 64'(drained), 64'd1);

    // Response with nothing outstanding: dropped, flag sticks.
    m_rvalid = 1'b1;
    repeat (4) tick();

    // Fetch at 0x104 left unanswered, then reset.
    hold_rsp = 1'b1;
    i_valid  = 1'b1;
    i_addr   = 32'h104;
    m_ready  = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    hold_rsp = 1'b0;
    tick();
    // The pending tag must be gone: this response is again unexpected.
    m_rvalid = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("exp_q_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-requester arbiter sharing the single RAM `membus` slave port between the core's instruction-fetch bus (32-bit, read-only) and its load/store bus (64-bit, read/write). It selects one request per cycle with data-side priority and an anti-starvation limit, and converts byte addresses to RAM word addresses. It tracks up to `OUTSTANDING` accepted requests in a tag FIFO and routes each in-order response back to the requester that issued it, selecting the correct 32-bit half for fetches. It sits between `core` and `memory` in `top`.

## Interface
- `RAM_ADDR_WIDTH`, 16: RAM word-address width.
- `RAM_DATA_WIDTH`, 64: RAM data width; also the d-side data width.
- `XLEN`, 32: byte-address width of both requesters.
- `OUTSTANDING`, 2: tag FIFO depth (≥1), i.e. the maximum number of accepted but unanswered requests.
- `MAX_D_STREAK`, 4: consecutive d grants allowed while i is waiting.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_valid`/`i_ready` in/out 1: fetch request handshake.
- `i_addr` in XLEN: fetch byte address.
- `i_rvalid` out 1, `i_rdata` out 32: fetch response.
- `d_valid`/`d_ready` in/out 1: load/store request handshake.
- `d_addr` in XLEN, `d_wen` in 1, `d_wdata` in 64, `d_wmask` in 8: load/store request.
- `d_rvalid` out 1, `d_rdata` out 64: load/store response.
- `m_valid`/`m_ready` out/in 1: slave request handshake.
- `m_addr` out RAM_ADDR_WIDTH, `m_wen` out 1, `m_wdata` out 64, `m_wmask` out 8: slave request.
- `m_rvalid` in 1, `m_rdata` in 64: slave response. Exactly one response per accepted request (reads and writes), returned in order.
- `err_unexpected` out 1: sticky flag, set when `m_rvalid` arrives while the tag FIFO is empty.

## Operation
- **Full flag.** `full` = (FIFO count == OUTSTANDING).
- **Grant.** Combinational, evaluated each cycle:
  - `full`: no grant; `m_valid`=0, `i_ready`=`d_ready`=0.
  - Else, only one requester valid: grant it.
  - Else, both valid: grant d, unless `streak`==MAX_D_STREAK, in which case grant i.
- **Request outputs.**
  - `m_valid` = granted requester's valid.
  - `i_ready` = `m_ready` AND grant==i.
  - `d_ready` = `m_ready` AND grant==d.
- **Request mux.**
  - `m_addr` = granted `addr[3 +: RAM_ADDR_WIDTH]`, where 3 = log2(RAM_DATA_WIDTH/8).
  - i granted: `m_wen`=0, `m_wdata`=0, `m_wmask`=0.
  - d granted: d fields pass through unchanged.
- **Accept.** An accept is `m_valid && m_ready`. On accept, push tag {src (0=i, 1=d), addr[2]} into the FIFO.
- **Streak counter** (width clog2(MAX_D_STREAK+1)):
  - Increments on a d accept while `i_valid`=1, saturating at MAX_D_STREAK.
  - Clears on an i accept, or on any cycle with `i_valid`=0.
- **Response routing.** On `m_rvalid` with FIFO non-empty, pop the head tag.
  - src=d: `d_rvalid`=1, `d_rdata`=`m_rdata`.
  - src=i: `i_rvalid`=1, `i_rdata` = head.addr[2] ? `m_rdata[63:32]` : `m_rdata[31:0]`.
  - The non-selected rvalid stays 0. `i_rdata`/`d_rdata` are driven 0 when their rvalid=0.
- **Unexpected response.** `m_rvalid` with FIFO empty: response dropped, both rvalids 0, `err_unexpected` set to 1 until reset.
- **Simultaneous push/pop.** Allowed; count is unchanged. Because `full` is computed before the pop, a full FIFO does not grant even when a pop occurs in the same cycle.

## Timing
- **Reset values.** FIFO empty, `streak`=0, `err_unexpected`=0. Hence `i_rvalid`=`d_rvalid`=0. `m_valid` follows inputs combinationally, since the FIFO is not full after reset.
- **Reset mid-operation.** In-flight tags are discarded. The slave is reset on the same `rst`, so it returns no stale responses.
- **Request path.** Combinational, zero added latency: an accept in cycle N is visible at the slave in cycle N.
- **Response path.** Combinational from `m_rvalid`/`m_rdata` to the requester in the same cycle.
- **FIFO and counter.** The tag push, FIFO pointers and streak counter all update at the rising edge ending the accept cycle.
- **Handshake stability.** Requesters hold valid and payload until ready. If grant moves away from a requester, it is not accepted that cycle and must keep waiting.

## Test plan
- **Priority.** i and d both valid with `m_ready`=1, OUTSTANDING=2, slave returns 1 cycle after accept -> d granted first (`d_ready`=1, `i_ready`=0), `m_addr`=`d_addr`>>3.
- **Starvation.** d continuously valid, i valid, MAX_D_STREAK=4, `m_ready`=1 -> 4 d grants, 5th grant is i, then d resumes; `streak` returns to 0 after the i accept.
- **Half-select.** Fetch at 0x104, then 0x100; slave returns `m_rdata`=0xAAAA_BBBB_CCCC_DDDD for both -> `i_rdata`=0xAAAA_BBBB, then 0xCCCC_DDDD; `d_rvalid` stays 0.
- **Full.** Accept 2 requests with no response -> `m_valid`=0 and both readys 0. Response arrives, pops in the same cycle -> still no grant that cycle; grant the next cycle.
- **Interleaved routing.** Order i(0x0), d-store(0x1000, wdata=1, wmask=0xFF), i(0x4) -> responses routed i, d, i in order. `m_wen`=1 only for the store; `m_wmask`=0 on i grants.
- **Unexpected response and reset.** `m_rvalid` with empty FIFO -> no rvalid out, `err_unexpected`=1 and held. Assert `rst` for 1 cycle with 1 tag pending -> flag 0 and FIFO empty after the edge.
